msrv32_irq_arbiter: RTL and testbench

- Machine-level external interrupt arbiter for the msrv32 core. It gathers NUM_SRC level-sensitive peripheral interrupt lines into per-source pending latches and applies an enable mask.
- It drives the single e_irq_in line of the machine control unit.
- Software claims the highest-priority source and later signals completion through a claim/complete handshake. A source is blocked from re-pending while it is in service.

---
 rtl/msrv32_irq_arbiter.sv | 148 ++++++++++++++
 tb/tb_msrv32_irq_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : msrv32_irq_arbiter
//  Purpose  : Machine-level external interrupt arbiter for the msrv32 core.
//             Latches NUM_SRC level-sensitive interrupt lines into pending
//             bits, masks them with an enable register, and drives the single
//             e_irq_in line of the machine control unit. Software claims the
//             lowest-index eligible source (ID = index + 1) and later hands it
//             back with a complete strobe. A source cannot re-pend while it is
//             in service.
//  Ports    : clock, reset_in       - clock / synchronous active-high reset
//             src_irq_in            - peripheral interrupt levels
//             cfg_we_in/cfg_wdata_in- enable register write
//             claim_in              - claim request strobe
//             complete_in/_id_in    - completion strobe and ID
//             e_irq_out             - interrupt request to machine control
//             claim_valid_out/_id_out - claim response (ID 0 = nothing)
//             pending_out, enable_out, in_service_out - CSR read-back
//  Revision : 1.0 - initial release
// ============================================================================
module msrv32_irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clock,
  input  logic               reset_in,
  input  logic [NUM_SRC-1:0] src_irq_in,
  input  logic               cfg_we_in,
  input  logic [NUM_SRC-1:0] cfg_wdata_in,
  input  logic               claim_in,
  input  logic               complete_in,
  input  logic [ID_W-1:0]    complete_id_in,
  output logic               e_irq_out,
  output logic               claim_valid_out,
  output logic [ID_W-1:0]    claim_id_out,
  output logic [NUM_SRC-1:0] pending_out,
  output logic [NUM_SRC-1:0] enable_out,
  output logic [NUM_SRC-1:0] in_service_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ASSERT = 3'b010,
    S_RESP   = 3'b100
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] in_service;
  logic [ID_W-1:0]    claim_id;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] gw_set;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] done_mask;
  logic [ID_W-1:0]    winner;
  logic               claim_take;

  assign elig   = pending & enable;
  // Gateway: a rising request is captured only when the source is neither
  // already pending nor being serviced.
  assign gw_set = src_irq_in & ~pending & ~in_service;

  // A claim is honoured exactly when the FSM moves into S_RESP; a claim seen
  // while already responding is dropped.
  assign claim_take = claim_in && (state != S_RESP);

  // Fixed priority: scan from the top so the lowest set index wins last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = ID_W'(i + 1);
      end
    end
  end

  // One-hot decodes of the claimed and completed sources. Comparing against
  // index + 1 makes ID 0 and out-of-range IDs fall through naturally.
  always_comb begin
    claim_mask = '0;
    done_mask  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask[i] = claim_take  && (winner         == ID_W'(i + 1));
      done_mask[i]  = complete_in && (complete_id_in == ID_W'(i + 1));
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (claim_in) begin
          state_nxt = S_RESP;
        end else if (elig != '0) begin
          state_nxt = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (claim_in) begin
          state_nxt = S_RESP;
        end else if (elig == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      state      <= S_IDLE;
      pending    <= '0;
      enable     <= '0;
      in_service <= '0;
      claim_id   <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= (pending | gw_set) & ~claim_mask;
      // Completion is applied before the claim, so a simultaneous claim and
      // complete of the same ID leaves the source in service.
      in_service <= (in_service & ~done_mask) | claim_mask;
      if (cfg_we_in) begin
        enable <= cfg_wdata_in;
      end
      if (claim_take) begin
        claim_id <= winner;
      end
    end
  end

  assign e_irq_out       = (state == S_ASSERT);
  assign claim_valid_out = (state == S_RESP);
  assign claim_id_out    = claim_id;
  assign pending_out     = pending;
  assign enable_out      = enable;
  assign in_service_out  = in_service;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msrv32_irq_arbiter
//  Purpose  : Directed self-checking bench for msrv32_irq_arbiter. Inputs are
//             changed 1 ns after each rising edge and outputs are sampled at
//             the same point, with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msrv32_irq_arbiter;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 5;

  logic               clock = 1'b0;
  logic               reset_in;
  logic [NUM_SRC-1:0] src_irq_in;
  logic               cfg_we_in;
  logic [NUM_SRC-1:0] cfg_wdata_in;
  logic               claim_in;
  logic               complete_in;
  logic [ID_W-1:0]    complete_id_in;
  logic               e_irq_out;
  logic               claim_valid_out;
  logic [ID_W-1:0]    claim_id_out;
  logic [NUM_SRC-1:0] pending_out;
  logic [NUM_SRC-1:0] enable_out;
  logic [NUM_SRC-1:0] in_service_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  msrv32_irq_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clock          (clock),
    .reset_in       (reset_in),
    .src_irq_in     (src_irq_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_wdata_in   (cfg_wdata_in),
    .claim_in       (claim_in),
    .complete_in    (complete_in),
    .complete_id_in (complete_id_in),
    .e_irq_out      (e_irq_out),
    .claim_valid_out(claim_valid_out),
    .claim_id_out   (claim_id_out),
    .pending_out    (pending_out),
    .enable_out     (enable_out),
    .in_service_out (in_service_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic regs(input string tag, input logic [7:0] pend, input logic [7:0] isvc,
                      input logic irq);
    chk({tag, ".pending"},    32'(pending_out),    32'(pend));
    chk({tag, ".in_service"}, 32'(in_service_out), 32'(isvc));
    chk({tag, ".e_irq"},      32'(e_irq_out),      32'(irq));
  endtask

  task automatic resp(input string tag, input logic vld, input logic [4:0] id);
    chk({tag, ".valid"}, 32'(claim_valid_out), 32'(vld));
    chk({tag, ".id"},    32'(claim_id_out),    32'(id));
  endtask

  task automatic write_en(input logic [7:0] val);
    cfg_we_in = 1'b1; cfg_wdata_in = val;
    step();
    cfg_we_in = 1'b0;
  endtask

  task automatic complete(input logic [4:0] id);
    complete_in = 1'b1; complete_id_in = id;
    step();
    complete_in = 1'b0; complete_id_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in = 1'b1; src_irq_in = '0; cfg_we_in = 1'b0; cfg_wdata_in = '0;
    claim_in = 1'b0; complete_in = 1'b0; complete_id_in = '0;
    #1;
    step(); step();
    reset_in = 1'b0;

    // Reset state
    regs("rst", 8'h00, 8'h00, 1'b0);
    resp("rst", 1'b0, 5'd0);
    chk("rst.enable", 32'(enable_out), 32'h00);

    // Reset mid-operation
    write_en(8'hFF);
    chk("rmo.enable", 32'(enable_out), 32'hFF);
    chk("rmo.e_irq0", 32'(e_irq_out), 32'h0);
    src_irq_in = 8'h08;
    step();
    chk("rmo.pend", 32'(pending_out), 32'h08);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0; src_irq_in = '0;
    regs("rmo.after", 8'h00, 8'h00, 1'b0);
    chk("rmo.enable_clr", 32'(enable_out), 32'h00);
    step();
    chk("rmo.e_irq1", 32'(e_irq_out), 32'h0);

    // Single source
    write_en(8'h08);
    src_irq_in = 8'h08;
    step();
    src_irq_in = 8'h00;
    regs("single.e1", 8'h08, 8'h00, 1'b0);
    step();
    regs("single.e2", 8'h08, 8'h00, 1'b1);
    claim_in = 1'b1;
    step();
    claim_in = 1'b0;
    resp("single.claim", 1'b1, 5'd4);
    regs("single.claim", 8'h00, 8'h08, 1'b0);
    step();
    resp("single.hold", 1'b0, 5'd4);
    chk("single.hold.e_irq", 32'(e_irq_out), 32'h0);
    complete(5'd4);
    chk("single.done", 32'(in_service_out), 32'h00);

    // Priority and ordering
    write_en(8'hFF);
    src_irq_in = 8'h24;
    step();
    regs("prio.p", 8'h24, 8'h00, 1'b0);
    step();
    chk("prio.irq", 32'(e_irq_out), 32'h1);
    claim_in = 1'b1;
    step();
    claim_in = 1'b0;
    resp("prio.c1", 1'b1, 5'd3);
    regs("prio.c1", 8'h20, 8'h04, 1'b0);
    step();
    chk("prio.idle", 32'(e_irq_out), 32'h0);
    step();
    chk("prio.reassert", 32'(e_irq_out), 32'h1);
    claim_in = 1'b1;
    step();
    claim_in = 1'b0;
    resp("prio.c2", 1'b1, 5'd6);
    regs("prio.c2", 8'h00, 8'h24, 1'b0);
    step(); step();
    regs("prio.quiet", 8'h00, 8'h24, 1'b0);

    // Complete and re-pend (src_irq_in[2] still high)
    complete(5'd3);
    regs("cmp.e1", 8'h00, 8'h20, 1'b0);
    step();
    regs("cmp.e2", 8'h04, 8'h20, 1'b0);
    step();
    regs("cmp.e3", 8'h04, 8'h20, 1'b1);
    complete(5'd0);
    regs("cmp.id0", 8'h04, 8'h20, 1'b1);
    complete(5'd9);
    regs("cmp.id9", 8'h04, 8'h20, 1'b1);
    src_irq_in = 8'h00;
    claim_in = 1'b1;
    step();
    claim_in = 1'b0;
    resp("cmp.reclaim", 1'b1, 5'd3);
    complete(5'd3);
    complete(5'd6);
    regs("cmp.clean", 8'h00, 8'h00, 1'b0);

    // Masking
    write_en(8'h00);
    src_irq_in = 8'h02;
    step();
    src_irq_in = 8'h00;
    regs("mask.pend", 8'h02, 8'h00, 1'b0);
    step();
    chk("mask.noirq", 32'(e_irq_out), 32'h0);
    write_en(8'h02);
    chk("mask.en_edge", 32'(e_irq_out), 32'h0);
    step();
    chk("mask.rise", 32'(e_irq_out), 32'h1);
    write_en(8'h00);
    chk("mask.dis_edge", 32'(e_irq_out), 32'h1);
    step();
    regs("mask.fall", 8'h02, 8'h00, 1'b0);

    // Spurious claim: nothing eligible
    claim_in = 1'b1;
    step();
    claim_in = 1'b0;
    resp("spur", 1'b1, 5'd0);
    regs("spur", 8'h02, 8'h00, 1'b0);
    step();
    chk("spur.end", 32'(claim_valid_out), 32'h0);

    // Claim together with enable write uses the old enable
    claim_in = 1'b1; cfg_we_in = 1'b1; cfg_wdata_in = 8'hFF;
    step();
    claim_in = 1'b0; cfg_we_in = 1'b0;
    resp("cwe", 1'b1, 5'd0);
    chk("cwe.enable", 32'(enable_out), 32'hFF);
    src_irq_in = 8'h01;
    step();
    src_irq_in = 8'h00;
    regs("cwe.idle", 8'h03, 8'h00, 1'b0);
    step();
    chk("cwe.irq", 32'(e_irq_out), 32'h1);

    // Back-to-back claims: the second one is ignored
    claim_in = 1'b1;
    step();
    resp("b2b.1", 1'b1, 5'd1);
    regs("b2b.1", 8'h02, 8'h01, 1'b0);
    step();
    claim_in = 1'b0;
    resp("b2b.2", 1'b0, 5'd1);
    regs("b2b.2", 8'h02, 8'h01, 1'b0);

    // Simultaneous claim and complete of the same ID
    claim_in = 1'b1; complete_in = 1'b1; complete_id_in = 5'd2;
    step();
    claim_in = 1'b0; complete_in = 1'b0; complete_id_in = '0;
    resp("cc", 1'b1, 5'd2);
    regs("cc", 8'h00, 8'h03, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
